// File: rtl/estagio_memoria_dados.sv
// Memory-access stage after the ALU: lh/sh against a word-organised data RAM,
// passthrough of the ALU result for non-memory ops. sh is a read-modify-write.
module estagio_memoria_dados #(
    parameter int PALAVRAS    = 64,
    parameter int LARGURA_IDX = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valido,
    output logic        pronto,
    input  logic        op_ler,
    input  logic        op_escrever,
    input  logic [31:0] endereco,
    input  logic [31:0] dado_escrita,
    output logic        resultado_valido,
    output logic [31:0] dado_lido,
    output logic        erro
);

    typedef enum logic [2:0] {
        OCIOSO,
        LER,
        MODIFICAR,
        ESCREVER,
        RESPONDER
    } estado_t;

    logic [31:0]            mem [PALAVRAS];
    estado_t                estado;
    logic [LARGURA_IDX-1:0] idx;
    logic                   meia;
    logic                   escrita;
    logic [15:0]            dado_sh;
    logic [31:0]            palavra;

    logic [31:0] lida;
    logic [15:0] meia_lida;
    logic        invalido;
    logic        sem_op;
    logic        dado_unused;

    assign lida        = mem[idx];
    assign meia_lida   = meia ? lida[31:16] : lida[15:0];
    assign sem_op      = !op_ler && !op_escrever;
    assign invalido    = (op_ler && op_escrever) || (!sem_op && endereco[0]);
    assign dado_unused = ^dado_escrita[31:16];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado           <= OCIOSO;
            pronto           <= 1'b1;
            resultado_valido <= 1'b0;
            dado_lido        <= '0;
            erro             <= 1'b0;
            idx              <= '0;
            meia             <= 1'b0;
            escrita          <= 1'b0;
            dado_sh          <= '0;
            palavra          <= '0;
        end else begin
            resultado_valido <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    if (valido) begin
                        pronto  <= 1'b0;
                        idx     <= endereco[LARGURA_IDX+1:2];
                        meia    <= endereco[1];
                        escrita <= op_escrever;
                        dado_sh <= dado_escrita[15:0];
                        if (invalido) begin
                            erro             <= 1'b1;
                            dado_lido        <= '0;
                            estado           <= RESPONDER;
                            resultado_valido <= 1'b1;
                        end else if (sem_op) begin
                            erro             <= 1'b0;
                            dado_lido        <= endereco;
                            estado           <= RESPONDER;
                            resultado_valido <= 1'b1;
                        end else begin
                            estado <= LER;
                        end
                    end
                end
                LER: begin
                    palavra <= lida;
                    if (escrita) begin
                        estado <= MODIFICAR;
                    end else begin
                        erro             <= 1'b0;
                        dado_lido        <= {{16{meia_lida[15]}}, meia_lida};
                        estado           <= RESPONDER;
                        resultado_valido <= 1'b1;
                    end
                end
                MODIFICAR: begin
                    if (meia) palavra[31:16] <= dado_sh;
                    else      palavra[15:0]  <= dado_sh;
                    estado <= ESCREVER;
                end
                ESCREVER: begin
                    erro             <= 1'b0;
                    dado_lido        <= '0;
                    estado           <= RESPONDER;
                    resultado_valido <= 1'b1;
                end
                RESPONDER: begin
                    estado <= OCIOSO;
                    pronto <= 1'b1;
                end
                default: begin
                    estado <= OCIOSO;
                    pronto <= 1'b1;
                end
            endcase
        end
    end

    // RAM is not reset; an asserted reset also suppresses the pending write
    always_ff @(posedge clock) begin
        if (reset && estado == ESCREVER) mem[idx] <= palavra;
    end

endmodule

// File: tb/tb_estagio_memoria_dados.sv
// Scoreboard bench for estagio_memoria_dados: directed lh/sh/passthrough vectors.
module tb_estagio_memoria_dados;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valido = 1'b0;
    logic        pronto;
    logic        op_ler = 1'b0;
    logic        op_escrever = 1'b0;
    logic [31:0] endereco = '0;
    logic [31:0] dado_escrita = '0;
    logic        resultado_valido;
    logic [31:0] dado_lido;
    logic        erro;

    estagio_memoria_dados #(.PALAVRAS(64), .LARGURA_IDX(6)) dut (
        .clock(clock),
        .reset(reset),
        .valido(valido),
        .pronto(pronto),
        .op_ler(op_ler),
        .op_escrever(op_escrever),
        .endereco(endereco),
        .dado_escrita(dado_escrita),
        .resultado_valido(resultado_valido),
        .dado_lido(dado_lido),
        .erro(erro)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [31:0] dado;
        logic        erro;
        int          ciclo;
        int          lat;
    } esperado_t;

    esperado_t fila[$];
    int ciclo = 0;
    int vetores = 0;
    int falhas = 0;

    always @(posedge clock) ciclo <= ciclo + 1;

    // monitor: every response pulse must match the head of the queue
    always @(negedge clock) begin
        if (reset && resultado_valido) begin
            vetores++;
            if (fila.size() == 0) begin
                falhas++;
                $display("FAIL resposta_inesperada: dado_lido=%h erro=%b",
                         dado_lido, erro);
            end else begin
                esperado_t e;
                e = fila.pop_front();
                if (dado_lido !== e.dado || erro !== e.erro ||
                    ciclo - e.ciclo != e.lat) begin
                    falhas++;
                    $display("FAIL resposta: got dado=%h erro=%b lat=%0d want dado=%h erro=%b lat=%0d",
                             dado_lido, erro, ciclo - e.ciclo, e.dado, e.erro, e.lat);
                end
            end
        end
    end

    task automatic checa(input string nome, input logic [31:0] got,
                         input logic [31:0] want);
        vetores++;
        if (got !== want) begin
            falhas++;
            $display("FAIL %s: got %h want %h", nome, got, want);
        end
    endtask

    task automatic req(input logic l, input logic e, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp,
                       input logic er, input int lat);
        int n;
        n = 0;
        @(negedge clock);
        while (!pronto && n < 20) begin
            @(negedge clock);
            n++;
        end
        valido       = 1'b1;
        op_ler       = l;
        op_escrever  = e;
        endereco     = a;
        dado_escrita = d;
        fila.push_back('{exp, er, ciclo, lat});
        @(negedge clock);
        valido      = 1'b0;
        op_ler      = 1'b0;
        op_escrever = 1'b0;
        checa("pronto_cai", {31'b0, pronto}, 32'd0);
        n = 0;
        while (fila.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (fila.size() != 0) begin
            falhas++;
            $display("FAIL timeout: end=%h pending=%0d want 0", a, fila.size());
            fila.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        checa("reset_pronto", {31'b0, pronto}, 32'd1);
        checa("reset_rv", {31'b0, resultado_valido}, 32'd0);
        checa("reset_dado", dado_lido, 32'd0);
        checa("reset_erro", {31'b0, erro}, 32'd0);
        reset = 1'b1;

        req(0, 0, 32'h0000_1234, 32'h0,         32'h0000_1234, 0, 1);
        req(0, 0, 32'hFFFF_FFFD, 32'h0,         32'hFFFF_FFFD, 0, 1);
        req(0, 1, 32'h0000_0008, 32'hFFFF_8001, 32'h0,         0, 4);
        req(1, 0, 32'h0000_0008, 32'h0,         32'hFFFF_8001, 0, 2);
        req(0, 1, 32'h0000_000A, 32'h0000_7FFF, 32'h0,         0, 4);
        req(1, 0, 32'h0000_000A, 32'h0,         32'h0000_7FFF, 0, 2);
        req(1, 0, 32'h0000_0008, 32'h0,         32'hFFFF_8001, 0, 2);
        req(1, 0, 32'h0000_0003, 32'h0,         32'h0,         1, 1);
        req(1, 1, 32'h0000_0008, 32'h0000_5555, 32'h0,         1, 1);
        req(0, 1, 32'h0000_0009, 32'h0000_1111, 32'h0,         1, 1);
        req(1, 0, 32'h0000_0008, 32'h0,         32'hFFFF_8001, 0, 2);
        req(1, 0, 32'h0000_000A, 32'h0,         32'h0000_7FFF, 0, 2);
        req(0, 1, 32'h0000_0100, 32'h0000_0042, 32'h0,         0, 4);
        req(1, 0, 32'h0000_0000, 32'h0,         32'h0000_0042, 0, 2);
        req(0, 1, 32'h0000_000C, 32'h0000_1234, 32'h0,         0, 4);
        req(1, 0, 32'h0000_000C, 32'h0,         32'h0000_1234, 0, 2);

        // sh aborted by reset while in MODIFICAR: no pulse, memory untouched
        @(negedge clock);
        valido       = 1'b1;
        op_escrever  = 1'b1;
        endereco     = 32'h0000_000C;
        dado_escrita = 32'h0000_BEEF;
        @(negedge clock);
        valido      = 1'b0;
        op_escrever = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checa("abort_pronto", {31'b0, pronto}, 32'd1);
        checa("abort_rv", {31'b0, resultado_valido}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        req(1, 0, 32'h0000_000C, 32'h0,         32'h0000_1234, 0, 2);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
        $finish;
    end

endmodule

// File: doc/estagio_memoria_dados.md
Name: estagio_memoria_dados

Overview:
- Memory-access stage directly downstream of the ALU. It consumes the ALU result as a byte address for lh/sh, or passes it through unchanged for non-memory instructions.
- Owns a word-organised data memory. Halfword stores are done as read-modify-write through a small FSM.
- Uses a valid/ready handshake on the request side and a one-cycle result-valid pulse on the response side.

Parameters:
PALAVRAS, 64, depth of data memory in 32-bit words (power of two)
LARGURA_IDX, 6, word-index width, equal to log2(PALAVRAS)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
valido  input  1  request present
pronto  output  1  stage can accept a request this cycle
op_ler  input  1  lh request
op_escrever  input  1  sh request
endereco  input  32  byte address (ALU result)
dado_escrita  input  32  store data; only [15:0] is used
resultado_valido  output  1  one-cycle pulse, response available
dado_lido  output  32  lh result (sign-extended), or passthrough value
erro  output  1  qualified by resultado_valido; misaligned access or conflicting op

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to OCIOSO; pronto=1, resultado_valido=0, dado_lido=0, erro=0.
  - Memory contents are not reset.
- Accept rule: a request is taken at a rising edge with valido=1 and pronto=1. endereco, dado_escrita and the op bits are latched on that edge.
- pronto=1 only in OCIOSO. Inputs are ignored while pronto=0.
- Address mapping:
  - word index = endereco[LARGURA_IDX+1:2]; upper bits are ignored, so the address wraps modulo 4*PALAVRAS.
  - endereco[1] selects the halfword: 0 selects [15:0], 1 selects [31:16] (little-endian).
- FSM states: OCIOSO, LER, MODIFICAR, ESCREVER, RESPONDER.
  - OCIOSO -> LER on an accepted lh or sh that passes the checks.
  - OCIOSO -> RESPONDER on an accepted passthrough or error request.
  - LER: registers the memory word. Next state is RESPONDER for lh, MODIFICAR for sh.
  - MODIFICAR: replaces the selected halfword with dado_escrita[15:0]; the other halfword is kept.
  - ESCREVER: writes the merged word to memory at the rising edge leaving this state, then goes to RESPONDER.
  - RESPONDER: resultado_valido=1 for exactly one cycle, then back to OCIOSO (pronto=1 the next cycle).
- Request classification, latched at accept:
  - op_ler=0 and op_escrever=0: passthrough; dado_lido=endereco, erro=0.
  - op_ler=1 and op_escrever=1: erro=1, dado_lido=0, no memory access.
  - lh or sh with endereco[0]=1: erro=1, dado_lido=0, no memory access.
  - lh: dado_lido = sign-extended selected halfword, erro=0.
  - sh: dado_lido=0, erro=0.
- Latency from the accept edge to resultado_valido high:
  - passthrough and error requests: 1 cycle.
  - lh: 2 cycles.
  - sh: 4 cycles.
- dado_lido and erro hold their value after the pulse until the next response. They are valid only while resultado_valido=1.
- Reset mid-operation: the FSM aborts to OCIOSO immediately.
  - An sh reset before the ESCREVER write edge leaves memory unchanged.
  - No resultado_valido pulse is issued for the aborted request.
- Back-to-back requests: a new request can be accepted at the edge where the FSM leaves RESPONDER for OCIOSO plus one cycle. The minimum spacing is latency+1 cycles.
- An sh followed by an lh to the same word must return the new data; there is no forwarding hazard because the stage is serialised.

Test Plan:
- Reset, then valido=1, op bits 00, endereco=0x0000_1234 -> pronto drops; 1 cycle later resultado_valido=1, dado_lido=0x0000_1234, erro=0.
- sh endereco=0x8, dado_escrita=0xFFFF_8001; then lh endereco=0x8 -> lh gives dado_lido=0xFFFF_8001 (sign-extended), 2 cycles after its accept.
- sh endereco=0xA, dado_escrita=0x7FFF, then lh 0xA and lh 0x8 -> 0x0000_7FFF and 0xFFFF_8001 (lower halfword preserved by RMW).
- lh endereco=0x3 and, separately, request with op_ler=op_escrever=1 -> each gives erro=1, dado_lido=0 after 1 cycle; memory unchanged (re-read 0x8 gives 0xFFFF_8001).
- Wrap: sh endereco=0x100 (PALAVRAS=64), dado_escrita=0x0042 -> lh endereco=0x0 returns 0x0000_0042.
- sh to 0xC with reset pulsed low during MODIFICAR -> FSM in OCIOSO, no resultado_valido pulse; lh 0xC returns the pre-existing value.
